// File: rtl/keccak_pkg.sv
// Shared Keccak constants: permutation state width, SHAKE rates and the
// squeezer FSM encoding.
package keccak_pkg;

    localparam int STATE_W       = 1600;
    localparam int SHAKE128_RATE = 1344;
    localparam int SHAKE256_RATE = 1088;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_PERM = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;
    localparam logic [1:0] ST_REQ       = 2'd3;

endpackage

// File: rtl/keccak_squeezer.sv
// SHAKE/XOF squeezer: captures the rate part of the permuted state, streams it
// out in W-bit words and requests bare permutations until num_words are sent.
module keccak_squeezer
    import keccak_pkg::*;
#(
    parameter int R     = SHAKE128_RATE,
    parameter int W     = 64,
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [LEN_W-1:0]   num_words,
    input  logic [STATE_W-1:0] perm_state,
    input  logic               perm_out_ready,
    output logic [R-1:0]       perm_in,
    output logic               perm_in_ready,
    input  logic               perm_ack,
    output logic [W-1:0]       dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy,
    output logic               done
);

    localparam int WORDS  = R / W;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [R-1:0]      buf_q, buf_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic              done_q, done_d;

    // Capacity bits never leave the permutation core.
    logic perm_state_unused;
    assign perm_state_unused = ^perm_state[STATE_W-R-1:0];

    // NOTE: every always_comb target gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        widx_d  = widx_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = num_words;
                        state_d = ST_WAIT_PERM;
                    end
                end
            end
            ST_WAIT_PERM: begin
                if (perm_out_ready) begin
                    buf_d   = perm_state[STATE_W-1 -: R];
                    widx_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dout_ready) begin
                    buf_d  = buf_q << W;
                    rem_d  = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
                    widx_d = (widx_q == LAST_WIDX) ? '0 : widx_q + WIDX_W'(1);
                    // A count of 0 here is unreachable; treating it as last
                    // keeps the FSM from streaming forever.
                    if (rem_q <= LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (widx_q == LAST_WIDX) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (perm_ack) begin
                    state_d = ST_WAIT_PERM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, regardless of statement order.
    // The word buffer is reset as well, since dout is defined to read 0 after reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            rem_q   <= '0;
            widx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            widx_q  <= widx_d;
            done_q  <= done_d;
        end
    end

    assign dout          = buf_q[R-1 -: W];
    assign dout_valid    = (state_q == ST_DRAIN);
    assign perm_in_ready = (state_q == ST_REQ);
    assign perm_in       = '0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_keccak_squeezer.sv
// Self-checking bench for keccak_squeezer: directed and random squeezes checked
// against a block-list model of the expected output stream.
module tb_keccak_squeezer;

    localparam int R     = 1344;
    localparam int W     = 64;
    localparam int LEN_W = 16;
    localparam int WPB   = R / W;

    logic              clk;
    logic              resetn;
    logic              start;
    logic [LEN_W-1:0]  num_words;
    logic [1599:0]     perm_state;
    logic              perm_out_ready;
    logic [R-1:0]      perm_in;
    logic              perm_in_ready;
    logic              perm_ack;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic [1599:0] preset[$];
    logic [1599:0] blocks[$];

    keccak_squeezer #(.R(R), .W(W), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .num_words      (num_words),
        .perm_state     (perm_state),
        .perm_out_ready (perm_out_ready),
        .perm_in        (perm_in),
        .perm_in_ready  (perm_in_ready),
        .perm_ack       (perm_ack),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Word k of the output stream is word k%WPB of the (k/WPB)-th permuted state.
    function automatic logic [63:0] expected_word(input int k);
        logic [1599:0] blk;
        blk = blocks[k / WPB];
        return blk[1599 - W * (k % WPB) -: W];
    endfunction

    // Runs one squeeze of n words. bp: 0 always ready, 1 fixed stall pattern,
    // 2 random ready. ack_delay: cycles perm_ack is held off per request.
    task automatic do_squeeze(input int n, input int bp, input int ack_delay);
        int k = 0, dones = 0, reqs = 0, cyc = 0, post = 0, pat_i = 0;
        int perm_wait, ack_wait = 0;
        bit req_active = 0, pulsed = 0, prev_stall = 0;
        logic [63:0] prev_dout = '0;
        logic [6:0]  pattern = 7'b1101001;  // bit 0 first: 1,0,0,1,0,1,1

        blocks.delete();
        perm_wait = (n == 0) ? -1 : 2;
        num_words = LEN_W'(n);
        start     = 1'b1;
        cycle();
        start = 1'b0;

        while (cyc < 3000) begin
            cyc++;
            perm_out_ready = 1'b0;
            perm_ack       = 1'b0;

            if (pulsed) check("valid_latency", 64'(dout_valid), 64'd1);
            pulsed = 0;
            if (prev_stall) check("stall_stable", dout, prev_dout);
            if (done) dones++;
            if (n == 0) check("zero_no_valid", 64'(dout_valid), 64'd0);

            if (!req_active && perm_in_ready) begin
                reqs++;
                check("perm_in_zero", 64'(perm_in == '0), 64'd1);
                req_active = 1;
                ack_wait   = ack_delay;
            end else if (req_active) begin
                check("req_held", 64'(perm_in_ready), 64'd1);
            end
            if (req_active) begin
                if (ack_wait == 0) begin
                    perm_ack   = 1'b1;
                    req_active = 0;
                    perm_wait  = 2;
                end else begin
                    ack_wait--;
                end
            end

            if (perm_wait == 0) begin
                perm_state     = (preset.size() > 0) ? preset.pop_front() : rand_state();
                blocks.push_back(perm_state);
                perm_out_ready = 1'b1;
                pulsed         = 1;
                perm_wait      = -1;
            end else if (perm_wait > 0) begin
                perm_wait--;
            end

            case (bp)
                0:       dout_ready = 1'b1;
                1:       dout_ready = pattern[pat_i % 7];
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (dout_valid) pat_i++;

            if (dout_valid && dout_ready) begin
                if (k / WPB < blocks.size()) check("word", dout, expected_word(k));
                else check("word_no_block", 64'd1, 64'd0);
                k++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;

            if (dones > 0) begin
                if (post == 3) break;
                post++;
            end
            cycle();
        end
        dout_ready = 1'b0;
        check("timeout", 64'(cyc >= 3000), 64'd0);
        check("word_count", 64'(k), 64'(n));
        check("done_count", 64'(dones), 64'd1);
        check("req_count", 64'(reqs), 64'((n == 0) ? 0 : (n - 1) / WPB));
        check("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1599:0] s;
        int n;

        resetn         = 1'b1;
        start          = 1'b0;
        num_words      = '0;
        perm_state     = rand_state();
        perm_out_ready = 1'b0;
        perm_ack       = 1'b0;
        dout_ready     = 1'b0;

        // Reset for two cycles with perm_out_ready pulsing.
        @(negedge clk);
        perm_out_ready = 1'b1;
        cycle();
        perm_out_ready = 1'b0;
        cycle();
        resetn = 1'b0;
        check("rst_dout", dout, 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_req", 64'(perm_in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_perm_in", 64'(perm_in == '0), 64'd1);
        perm_out_ready = 1'b1;
        cycle();
        perm_out_ready = 1'b0;
        cycle();
        check("idle_no_capture_valid", 64'(dout_valid), 64'd0);
        check("idle_no_capture_busy", 64'(busy), 64'd0);

        // Three directed words.
        s = rand_state();
        s[1599 -: 192] = 192'h0123456789ABCDEF_1111111111111111_2222222222222222;
        preset.push_back(s);
        do_squeeze(3, 0, 0);

        // Exactly one full block, then one word past it with a slow ack.
        do_squeeze(WPB, 0, 0);
        s = rand_state();
        s[1599 -: 64] = 64'hDEADBEEFCAFEF00D;
        preset.push_back(rand_state());
        preset.push_back(s);
        do_squeeze(WPB + 1, 0, 5);
        check("word22_model", expected_word(WPB), 64'hDEADBEEFCAFEF00D);

        // Backpressure and zero-length request.
        do_squeeze(4, 1, 0);
        do_squeeze(0, 0, 0);

        // Reset in the middle of DRAIN, with a start while busy that must be ignored.
        num_words = 16'd5;
        start     = 1'b1;
        cycle();
        start          = 1'b0;
        perm_state     = rand_state();
        perm_out_ready = 1'b1;
        cycle();
        perm_out_ready = 1'b0;
        num_words      = 16'd9;
        start          = 1'b1;
        check("mid_valid_before", 64'(dout_valid), 64'd1);
        cycle();
        start  = 1'b0;
        resetn = 1'b1;
        cycle();
        resetn = 1'b0;
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_dout", dout, 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        do_squeeze(3, 0, 0);

        // Random lengths, backpressure and ack delays.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 3 * WPB);
            do_squeeze(n, 2, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_squeezer.md
Name: keccak_squeezer

Overview:
- Read-side companion of the Keccak f-permutation core for the SHAKE/XOF paths of Kyber512 (matrix and noise sampling).
- After the absorber's final block permutes, it captures the rate portion of the state and streams it out as W-bit words under valid/ready.
- When more output is needed, it drives an all-zero rate block into the permutation's in/in_ready/ack port, which triggers a bare permutation, and repeats until the requested word count has been delivered.

Parameters:
- R, 1344, rate in bits (1344 = SHAKE128, 1088 = SHAKE256). R must be a multiple of W.
- W, 64, output word width in bits.
- LEN_W, 16, width of the requested word count.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-high reset (despite the name); sampled on posedge clk.
- start  in  1  one-cycle pulse that begins a squeeze; ignored unless in IDLE.
- num_words  in  LEN_W  number of W-bit words to emit; sampled when start is accepted.
- perm_state  in  1600  permutation state register (f-permutation out).
- perm_out_ready  in  1  one-cycle pulse from the permutation marking a completed permutation.
- perm_in  out  R  block presented to the permutation; constant zero.
- perm_in_ready  out  1  request for one permutation.
- perm_ack  in  1  permutation accepted the block (combinational in the same cycle).
- dout  out  W  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  sink accepts dout.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last word is accepted, or when a zero-length request is accepted.

Behaviour:
- Reset: state goes to IDLE and all counters and the buffer clear. dout=0, dout_valid=0, perm_in_ready=0, busy=0, done=0. perm_in is always 0.
- Reset mid-operation (any state) aborts immediately; outputs take their reset values on the next edge. The permutation core is not reset by this block.
- Shift buffer: buf[R-1:0]. A capture loads buf <= perm_state[1599 -: R]. dout = buf[R-1 -: W], so the first word of each block is perm_state[1599 -: W]. No byte swapping.
- Counters:
  - rem (LEN_W bits): words still to emit.
  - widx: word index within the current block, 0..R/W-1.
- IDLE:
  - start with num_words=0: pulse done next cycle, stay IDLE.
  - start with num_words>0: rem <= num_words, then WAIT_PERM.
  - perm_out_ready is ignored in IDLE.
- WAIT_PERM:
  - On perm_out_ready: capture buf, widx <= 0, go to DRAIN.
  - dout_valid rises on the cycle after the pulse (latency 1).
- DRAIN:
  - dout_valid=1. dout is held stable while dout_valid && !dout_ready.
  - On each handshake: buf shifts left by W, rem decrements, widx increments.
  - Handshake with rem==1: done pulses next cycle, go to IDLE, dout_valid drops.
  - Otherwise, handshake with widx==R/W-1 (rem>1): go to REQ, dout_valid drops.
- REQ:
  - perm_in_ready=1 until the cycle in which perm_ack=1, then go to WAIT_PERM.
  - A delayed ack (permutation still calculating) is held indefinitely.
- perm_out_ready arriving in DRAIN or REQ is ignored; it cannot occur legally in those states.
- start while busy is ignored.
- rem is never decremented below 0 and never wraps.

Decomposition:
- Shared package keccak_pkg holds:
  - STATE_W=1600.
  - SHAKE128_RATE=1344 and SHAKE256_RATE=1088.
  - The squeezer state encoding IDLE/WAIT_PERM/DRAIN/REQ.
- No sub-module: the buffer, counters and FSM stay in one module.

Test Plan:
- Reset with resetn=1 for 2 cycles, with perm_out_ready pulsing during reset -> all outputs 0, busy=0; no capture after release.
- start with num_words=3, then perm_out_ready with perm_state[1599-:192]=0x0123456789ABCDEF_1111111111111111_2222222222222222, dout_ready=1 -> dout equals those three words on consecutive cycles starting 1 cycle after the pulse; done pulses once; perm_in_ready never rises.
- num_words=21 (R=1344, W=64) -> exactly 21 words from a single capture; done; no REQ.
- num_words=22 -> after word 21, perm_in_ready=1 with perm_in=0; ack is held off 5 cycles and perm_in_ready stays high until it arrives; after a perm_out_ready whose state[1599-:64]=0xDEADBEEFCAFEF00D, word 22 = 0xDEADBEEFCAFEF00D; done pulses.
- Backpressure: num_words=4 with dout_ready toggling 1,0,0,1,0,1,1 -> dout stable while stalled; exactly 4 handshakes; words in order.
- num_words=0 -> done pulses 1 cycle after start; dout_valid stays 0.
- resetn asserted in the middle of DRAIN -> IDLE next edge, dout_valid=0, busy=0; a following start works normally.
